// File: rtl/sin_inverse_search_if.sv
// Handshake and ROM-port bundle for the quarter-wave sine inverse search.
// The slave side is the search engine; the master side drives samples,
// takes results and hosts the registered sine ROM.
interface sin_inverse_search_if #(
    parameter int PHASE_WIDTH = 8,
    parameter int AMP_WIDTH   = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [AMP_WIDTH-1:0]   in_amp;
    logic [PHASE_WIDTH-1:0] lut_addr;
    logic [AMP_WIDTH-1:0]   lut_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [PHASE_WIDTH-1:0] out_phase;

    modport master (
        output in_valid,
        output in_amp,
        output out_ready,
        output lut_data,
        input  in_ready,
        input  lut_addr,
        input  out_valid,
        input  out_phase
    );

    modport slave (
        input  in_valid,
        input  in_amp,
        input  out_ready,
        input  lut_data,
        output in_ready,
        output lut_addr,
        output out_valid,
        output out_phase
    );
endinterface

// File: rtl/sin_inverse_search.sv
// Successive-approximation inverse of a monotone quarter-wave sine ROM.
// Each phase bit costs two cycles: PROBE lets the registered ROM sample the
// candidate address, CMP compares the returned word against the latched
// amplitude and keeps the bit when rom[candidate] <= amplitude. Because the
// ROM is non-decreasing with rom[0]=0, this yields the largest index whose
// word does not exceed the amplitude (plateaus resolve to their top index).
module sin_inverse_search #(
    parameter int PHASE_WIDTH = 8,
    parameter int AMP_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sin_inverse_search_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_CMP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One-hot mask of the most significant phase bit, tried first.
    localparam logic [PHASE_WIDTH-1:0] MSB_MASK = PHASE_WIDTH'(1'b1) << (PHASE_WIDTH - 1);

    state_t                 state_r;
    logic [AMP_WIDTH-1:0]   amp_r;
    logic [PHASE_WIDTH-1:0] res_r;
    logic [PHASE_WIDTH-1:0] mask_r;
    logic [PHASE_WIDTH-1:0] lut_addr_r;
    logic [PHASE_WIDTH-1:0] out_phase_r;
    logic                   in_ready_r;
    logic                   out_valid_r;

    logic [PHASE_WIDTH-1:0] cand_s;
    logic [PHASE_WIDTH-1:0] res_next_s;
    logic [PHASE_WIDTH-1:0] addr_next_s;
    logic                   hit_s;

    // Unsigned full-width compare of a ROM word against the target amplitude.
    function automatic logic word_fits(input logic [AMP_WIDTH-1:0] word,
                                       input logic [AMP_WIDTH-1:0] amp);
        return (word <= amp);
    endfunction

    // Compare step: keep the candidate bit when the probed ROM word fits,
    // and form the next probe address from the updated result.
    always_comb begin
        cand_s = res_r | mask_r;
        hit_s  = word_fits(bus.lut_data, amp_r);
        if (hit_s) begin
            res_next_s = cand_s;
        end else begin
            res_next_s = res_r;
        end
        addr_next_s = res_next_s | (mask_r >> 1'b1);
    end

    // Search FSM with registered handshake outputs and ROM address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            amp_r       <= '0;
            res_r       <= '0;
            mask_r      <= '0;
            lut_addr_r  <= '0;
            out_phase_r <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        amp_r      <= bus.in_amp;
                        res_r      <= '0;
                        mask_r     <= MSB_MASK;
                        lut_addr_r <= MSB_MASK;
                        in_ready_r <= 1'b0;
                        state_r    <= ST_PROBE;
                    end else begin
                        in_ready_r <= 1'b1;
                        state_r    <= ST_IDLE;
                    end
                end
                ST_PROBE: begin
                    // ROM samples lut_addr_r on this edge; data is ready for CMP.
                    state_r <= ST_CMP;
                end
                ST_CMP: begin
                    res_r <= res_next_s;
                    if (mask_r[0]) begin
                        out_phase_r <= res_next_s;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        mask_r     <= mask_r >> 1'b1;
                        lut_addr_r <= addr_next_s;
                        state_r    <= ST_PROBE;
                    end
                end
                ST_DONE: begin
                    if (out_valid_r && bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_phase = out_phase_r;
    assign bus.lut_addr  = lut_addr_r;

endmodule

// File: tb/tb_sin_inverse_search.sv
// Directed bench for sin_inverse_search with a registered ROM model.
// The ROM is a monotone table pinned at the anchor points used below:
// rom[1]=2, rom[2]=3, rom[85]=127, rom[86]=129, rom[149]=rom[150]=203,
// rom[151]=204, rom[255]=255.
module tb_sin_inverse_search;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    logic [7:0] rom [256];

    sin_inverse_search_if #(.PHASE_WIDTH(8), .AMP_WIDTH(8)) bus ();

    sin_inverse_search #(.PHASE_WIDTH(8), .AMP_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ROM: one-cycle read latency.
    always @(posedge clk) bus.lut_data <= rom[bus.lut_addr];

    function automatic logic [7:0] rom_val(input int a);
        if (a == 0)        return 8'd0;
        else if (a == 1)   return 8'd2;
        else if (a == 2)   return 8'd3;
        else if (a <= 85)  return 8'(a + (a * 42) / 85);
        else if (a <= 148) return 8'(129 + (a - 86));
        else if (a <= 150) return 8'd203;
        else               return 8'(204 + ((a - 151) * 51) / 104);
    endfunction

    // Reference: linear scan for the largest index whose word fits.
    function automatic logic [7:0] ref_phase(input logic [7:0] amp);
        logic [7:0] best;
        best = 8'd0;
        for (int a = 0; a < 256; a++) begin
            if (rom[a] <= amp) best = 8'(a);
        end
        return best;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1 with the DUT idle; returns with the DUT idle again.
    task automatic do_search(input logic [7:0] amp, output logic [7:0] ph, output int lat);
        check("in_ready before accept", 32'(bus.in_ready), 32'd1);
        bus.in_amp   = amp;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        ph = bus.out_phase;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    typedef struct packed {
        logic [7:0] amp;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ph;
        logic [7:0] exp_addr;
        int         lat;
        logic       ok;

        tests = 0;
        fails = 0;
        for (int a = 0; a < 256; a++) rom[a] = rom_val(a);

        vecs[0] = '{amp: 8'h00, exp: 8'h00};
        vecs[1] = '{amp: 8'h02, exp: 8'h01};
        vecs[2] = '{amp: 8'h01, exp: 8'h00};
        vecs[3] = '{amp: 8'h80, exp: 8'h55};
        vecs[4] = '{amp: 8'hCB, exp: 8'h96};
        vecs[5] = '{amp: 8'hFF, exp: 8'hFF};
        vecs[6] = '{amp: 8'h03, exp: 8'h02};
        vecs[7] = '{amp: 8'h7F, exp: 8'h55};
        vecs[8] = '{amp: 8'hCC, exp: 8'h99};
        vecs[9] = '{amp: 8'hCA, exp: 8'h94};

        // Reset state
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_amp    = 8'h00;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset out_phase", 32'(bus.out_phase), 32'd0);
        check("reset lut_addr", 32'(bus.lut_addr), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // amp 0: walk the address sequence 0x80 .. 0x01 and the exact latency
        bus.in_amp   = 8'h00;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("in_ready after accept", 32'(bus.in_ready), 32'd0);
        check("addr bit7", 32'(bus.lut_addr), 32'h80);
        for (int k = 6; k >= 0; k--) begin
            repeat (2) @(posedge clk);
            #1;
            exp_addr = 8'h01 << k;
            check("addr walk", 32'(bus.lut_addr), 32'(exp_addr));
        end
        @(posedge clk); #1;
        check("out_valid edge15", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        check("out_valid edge16", 32'(bus.out_valid), 32'd1);
        check("phase amp0", 32'(bus.out_phase), 32'd0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("handshake out_valid", 32'(bus.out_valid), 32'd0);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            do_search(vecs[i].amp, ph, lat);
            check("table phase", 32'(ph), 32'(vecs[i].exp));
            check("table latency", 32'(lat), 32'd16);
        end

        // Backpressure with in_valid held high; the second amplitude (0x10)
        // must only be taken after the result handshake.
        bus.in_amp   = 8'h80;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_amp = 8'h10;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp latency", 32'(lat), 32'd16);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("bp out_phase stable", 32'(bus.out_phase), 32'h55);
            check("bp in_ready low", 32'(bus.in_ready), 32'd0);
            check("bp out_valid held", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("bp handshake out_valid", 32'(bus.out_valid), 32'd0);
        check("bp handshake in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp second accept", 32'(bus.in_ready), 32'd0);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp second latency", 32'(lat), 32'd16);
        check("bp second phase", 32'(bus.out_phase), 32'h0B);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        // Reset sampled on the CMP edge of bit 4 (eighth edge after accept)
        bus.in_amp   = 8'hFF;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midreset in_ready", 32'(bus.in_ready), 32'd1);
        check("midreset out_valid", 32'(bus.out_valid), 32'd0);
        check("midreset out_phase", 32'(bus.out_phase), 32'd0);
        do_search(8'h80, ph, lat);
        check("post-reset phase", 32'(ph), 32'h55);
        check("post-reset latency", 32'(lat), 32'd16);

        // Full sweep against the linear reference and the defining property
        for (int a = 0; a < 256; a++) begin
            do_search(8'(a), ph, lat);
            check("sweep phase", 32'(ph), 32'(ref_phase(8'(a))));
            ok = (rom[ph] <= 8'(a)) && ((ph == 8'hFF) || (rom[ph + 8'd1] > 8'(a)));
            check("sweep property", 32'(ok), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
